// File: rtl/eth_idma_arb_pkg.sv
// ----------------------------------------------------------------------------
// eth_idma_arb_pkg: shared types for the Ethernet iDMA request arbiter.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package eth_idma_arb_pkg;

  localparam int unsigned ADDR_WIDTH  = 32;
  localparam int unsigned TFLEN_WIDTH = 32;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]  src_addr;
    logic [ADDR_WIDTH-1:0]  dst_addr;
    logic [TFLEN_WIDTH-1:0] length;
  } xfer_t;

  typedef enum logic {
    REQ_TX = 1'b0,
    REQ_RX = 1'b1
  } req_id_e;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } arb_state_e;

  function automatic req_id_e other_req(input req_id_e id);
    return (id == REQ_TX) ? REQ_RX : REQ_TX;
  endfunction

endpackage

`default_nettype wire

// File: rtl/eth_idma_req_arb_if.sv
// ----------------------------------------------------------------------------
// eth_idma_req_arb_if: descriptor request + completion handshake bundle.
// Rev 1.0. Request field packs {src_addr, dst_addr, length}.
// ----------------------------------------------------------------------------
`default_nettype none

interface eth_idma_req_arb_if #(
  parameter int unsigned AddrWidth  = eth_idma_arb_pkg::ADDR_WIDTH,
  parameter int unsigned TFLenWidth = eth_idma_arb_pkg::TFLEN_WIDTH
) ();

  logic [2*AddrWidth+TFLenWidth-1:0] req;
  logic                              req_valid;
  logic                              req_ready;
  logic                              rsp_valid;
  logic                              rsp_error;
  logic                              rsp_ready;

  modport master (
    output req, req_valid, rsp_ready,
    input  req_ready, rsp_valid, rsp_error
  );

  modport slave (
    input  req, req_valid, rsp_ready,
    output req_ready, rsp_valid, rsp_error
  );

endinterface

`default_nettype wire

// File: rtl/eth_idma_arb_route_fifo.sv
// ----------------------------------------------------------------------------
// eth_idma_arb_route_fifo: 1-bit requester-ID FIFO with wrap-bit pointers.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module eth_idma_arb_route_fifo #(
  parameter  int unsigned Depth    = 4,
  localparam int unsigned PtrWidth = $clog2(Depth)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  logic data_i,
  input  logic pop_i,
  output logic data_o,
  output logic empty_o
);

  logic [Depth-1:0]  mem_q;
  logic [PtrWidth:0] wptr_q;
  logic [PtrWidth:0] rptr_q;
  logic              full;
  logic              do_push;
  logic              do_pop;

  // Same index with differing wrap bits means the writer lapped the reader.
  assign empty_o = (wptr_q == rptr_q);
  assign full    = (wptr_q[PtrWidth] != rptr_q[PtrWidth]) &&
                   (wptr_q[PtrWidth-1:0] == rptr_q[PtrWidth-1:0]);
  assign do_push = push_i && !full;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rptr_q[PtrWidth-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q[PtrWidth-1:0]] <= data_i;
        wptr_q                      <= wptr_q + (PtrWidth+1)'(1);
      end
      if (do_pop) begin
        rptr_q <= rptr_q + (PtrWidth+1)'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/eth_idma_req_arb.sv
// ----------------------------------------------------------------------------
// eth_idma_req_arb: round-robin TX/RX scheduler for the iDMA request port.
// Rev 1.0. Define ETH_IDMA_ARB_STATS_EN for completion/error counters.
// ----------------------------------------------------------------------------
`default_nettype none

module eth_idma_req_arb
  import eth_idma_arb_pkg::*;
#(
  parameter  int unsigned AddrWidth      = 32,
  parameter  int unsigned TFLenWidth     = 32,
  parameter  int unsigned MaxOutstanding = 4,
  localparam int unsigned CntWidth       = $clog2(MaxOutstanding) + 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  eth_idma_req_arb_if.slave   tx_if,
  eth_idma_req_arb_if.slave   rx_if,
  eth_idma_req_arb_if.master  idma_if,
  output logic                busy_o,
  output logic [CntWidth-1:0] outstanding_o
`ifdef ETH_IDMA_ARB_STATS_EN
  ,
  output logic [31:0]         tx_done_cnt_o,
  output logic [31:0]         rx_done_cnt_o,
  output logic [31:0]         err_cnt_o
`endif
);

  localparam int unsigned XferWidth = 2*AddrWidth + TFLenWidth;

  arb_state_e             state_q, state_d;
  req_id_e                rr_q, rr_d;
  logic [CntWidth-1:0]    count_q, count_d;
  logic [XferWidth-1:0]   req_q, req_d;

  logic    grant;
  req_id_e winner;
  logic    can_grant;
  logic    fifo_empty;
  logic    head_bit;
  req_id_e head;
  logic    rsp_fire;

  // Grant eligibility uses the registered count only, so a completion in the
  // same cycle never opens a slot early.
  assign can_grant = (count_q < CntWidth'(MaxOutstanding));

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    req_d   = req_q;
    grant   = 1'b0;
    winner  = REQ_TX;
    case (state_q)
      IDLE: begin
        if (can_grant && (tx_if.req_valid || rx_if.req_valid)) begin
          grant = 1'b1;
          if (tx_if.req_valid && rx_if.req_valid) begin
            winner = rr_q;
          end else if (rx_if.req_valid) begin
            winner = REQ_RX;
          end else begin
            winner = REQ_TX;
          end
          rr_d    = other_req(winner);
          req_d   = (winner == REQ_RX) ? rx_if.req : tx_if.req;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (idma_if.req_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({grant, rsp_fire})
      2'b10:   count_d = count_q + CntWidth'(1);
      2'b01:   count_d = count_q - CntWidth'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      rr_q    <= REQ_TX;
      count_q <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      count_q <= count_d;
      req_q   <= req_d;
    end
  end

  eth_idma_arb_route_fifo #(
    .Depth (MaxOutstanding)
  ) u_route_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (grant),
    .data_i  (winner == REQ_RX),
    .pop_i   (rsp_fire),
    .data_o  (head_bit),
    .empty_o (fifo_empty)
  );

  assign head = req_id_e'(head_bit);

  assign tx_if.req_ready = grant && (winner == REQ_TX);
  assign rx_if.req_ready = grant && (winner == REQ_RX);

  assign idma_if.req       = req_q;
  assign idma_if.req_valid = (state_q == ISSUE);

  // Completions come back in issue order; the FIFO head names the owner.
  assign tx_if.rsp_valid  = !fifo_empty && (head == REQ_TX) && idma_if.rsp_valid;
  assign rx_if.rsp_valid  = !fifo_empty && (head == REQ_RX) && idma_if.rsp_valid;
  assign tx_if.rsp_error  = !fifo_empty && (head == REQ_TX) && idma_if.rsp_error;
  assign rx_if.rsp_error  = !fifo_empty && (head == REQ_RX) && idma_if.rsp_error;
  assign idma_if.rsp_ready = !fifo_empty &&
                             ((head == REQ_RX) ? rx_if.rsp_ready : tx_if.rsp_ready);
  assign rsp_fire = idma_if.rsp_valid && idma_if.rsp_ready;

  assign busy_o        = (count_q != '0) || (state_q == ISSUE);
  assign outstanding_o = count_q;

`ifdef ETH_IDMA_ARB_STATS_EN
  logic [31:0] tx_done_q;
  logic [31:0] rx_done_q;
  logic [31:0] err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_done_q <= '0;
      rx_done_q <= '0;
      err_q     <= '0;
    end else if (rsp_fire) begin
      if (head == REQ_TX) begin
        tx_done_q <= tx_done_q + 32'd1;
      end else begin
        rx_done_q <= rx_done_q + 32'd1;
      end
      if (idma_if.rsp_error) begin
        err_q <= err_q + 32'd1;
      end
    end
  end

  assign tx_done_cnt_o = tx_done_q;
  assign rx_done_cnt_o = rx_done_q;
  assign err_cnt_o     = err_q;
`endif

  a_no_rsp_when_empty: assert property (
    @(posedge clk_i) disable iff (!rst_ni) !(idma_if.rsp_valid && fifo_empty)
  );

endmodule

`default_nettype wire

// File: tb/tb_eth_idma_req_arb.sv
// ----------------------------------------------------------------------------
// tb_eth_idma_req_arb: directed and randomized bench for eth_idma_req_arb.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_eth_idma_req_arb;
  import eth_idma_arb_pkg::*;

  localparam int MAXO = 4;
  localparam int CW   = 3;

  logic clk    = 1'b0;
  logic rst_ni = 1'b1;
  always #5 clk = ~clk;

  eth_idma_req_arb_if #(.AddrWidth(32), .TFLenWidth(32)) tx_if ();
  eth_idma_req_arb_if #(.AddrWidth(32), .TFLenWidth(32)) rx_if ();
  eth_idma_req_arb_if #(.AddrWidth(32), .TFLenWidth(32)) idma_if ();

  logic          busy;
  logic [CW-1:0] outstanding;
`ifdef ETH_IDMA_ARB_STATS_EN
  logic [31:0] tx_done_cnt, rx_done_cnt, err_cnt;
`endif

  eth_idma_req_arb #(
    .AddrWidth      (32),
    .TFLenWidth     (32),
    .MaxOutstanding (MAXO)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .tx_if         (tx_if),
    .rx_if         (rx_if),
    .idma_if       (idma_if),
    .busy_o        (busy),
    .outstanding_o (outstanding)
`ifdef ETH_IDMA_ARB_STATS_EN
    ,
    .tx_done_cnt_o (tx_done_cnt),
    .rx_done_cnt_o (rx_done_cnt),
    .err_cnt_o     (err_cnt)
`endif
  );

  logic [11:0] obs;
  assign obs = {tx_if.req_ready, rx_if.req_ready, idma_if.req_valid, outstanding, busy,
                tx_if.rsp_valid, rx_if.rsp_valid, tx_if.rsp_error, rx_if.rsp_error,
                idma_if.rsp_ready};

  // Reference model: in-flight owners in issue order, rr pointer, pending issue.
  bit          m_q[$];
  bit          m_rr;
  bit          m_issuing;
  xfer_t       m_desc;
  int unsigned m_done[2];
  int unsigned m_err;

  int n_tests;
  int n_fail;

  function automatic void model_reset();
    m_q.delete();
    m_rr      = 1'b0;
    m_issuing = 1'b0;
    m_desc    = '0;
    m_done[0] = 0;
    m_done[1] = 0;
    m_err     = 0;
  endfunction

  function automatic void model_grant(output bit g, output bit w);
    bit tv, rv;
    tv = tx_if.req_valid;
    rv = rx_if.req_valid;
    g  = !m_issuing && (m_q.size() < MAXO) && (tv || rv);
    w  = (tv && rv) ? m_rr : rv;
  endfunction

  function automatic logic [11:0] exp_vec();
    bit g, w, hv, hd, rdy;
    model_grant(g, w);
    hv  = (m_q.size() != 0);
    hd  = hv ? m_q[0] : 1'b0;
    rdy = hd ? rx_if.rsp_ready : tx_if.rsp_ready;
    return {g & ~w, g & w, m_issuing, CW'(m_q.size()), hv | m_issuing,
            hv & ~hd & idma_if.rsp_valid, hv & hd & idma_if.rsp_valid,
            hv & ~hd & idma_if.rsp_error, hv & hd & idma_if.rsp_error, hv & rdy};
  endfunction

  function automatic void model_step();
    bit g, w, pop;
    model_grant(g, w);
    pop = (m_q.size() != 0) && idma_if.rsp_valid &&
          (m_q[0] ? rx_if.rsp_ready : tx_if.rsp_ready);
    if (pop) begin
      m_done[m_q[0]]++;
      if (idma_if.rsp_error) m_err++;
      void'(m_q.pop_front());
    end
    if (m_issuing && idma_if.req_ready) m_issuing = 1'b0;
    if (g) begin
      m_q.push_back(w);
      m_rr      = !w;
      m_issuing = 1'b1;
      m_desc    = w ? rx_if.req : tx_if.req;
    end
  endfunction

  task automatic clear_inputs();
    tx_if.req = '0;  tx_if.req_valid = 1'b0;  tx_if.rsp_ready = 1'b0;
    rx_if.req = '0;  rx_if.req_valid = 1'b0;  rx_if.rsp_ready = 1'b0;
    idma_if.req_ready = 1'b0;  idma_if.rsp_valid = 1'b0;  idma_if.rsp_error = 1'b0;
  endtask

  task automatic advance();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
    model_reset();
  endtask

  function automatic xfer_t rand_xfer();
    return {$urandom, $urandom, $urandom};
  endfunction

  task automatic test_reset();
    clear_inputs();
    #2 rst_ni = 1'b0;
    #1;
    n_tests++;
    if (obs !== 12'd0 || idma_if.req !== '0) begin
      n_fail++;
      $display("FAIL reset_async: got %b req %h, want 0", obs, idma_if.req);
    end
    @(posedge clk);
    #1 rst_ni = 1'b1;
    model_reset();
    #1;
    n_tests++;
    if (obs !== exp_vec() || idma_if.req !== '0) begin
      n_fail++;
      $display("FAIL reset_release: got %b req %h, want %b req 0", obs, idma_if.req, exp_vec());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_tx_single();
    xfer_t d;
    do_reset();
    d = {32'h0, 32'h98001032, 32'd8};
    for (int c = 0; c < 6; c++) begin
      tx_if.req         = d;
      tx_if.req_valid   = (c == 0);
      tx_if.rsp_ready   = 1'b1;
      idma_if.req_ready = 1'b1;
      idma_if.rsp_valid = (c == 3);
      #1;
      n_tests++;
      if (obs !== exp_vec() || (m_issuing && idma_if.req !== m_desc)) begin
        n_fail++;
        $display("FAIL tx_single cyc %0d: got %b want %b", c, obs, exp_vec());
      end
      if (c == 1) begin
        n_tests++;
        if (idma_if.req_valid !== 1'b1 || idma_if.req !== d) begin
          n_fail++;
          $display("FAIL tx_single_issue: got v=%b req %h want v=1 req %h",
                   idma_if.req_valid, idma_if.req, d);
        end
      end
      advance();
    end
    n_tests++;
    if (outstanding !== 3'd0) begin
      n_fail++;
      $display("FAIL tx_single_drain: got outstanding %0d want 0", outstanding);
    end
  endtask

  task automatic test_rr_both();
    logic [3:0] gv, rv;
    int ng, nr;
    gv = '0; rv = '0; ng = 0; nr = 0;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      tx_if.req         = rand_xfer();
      rx_if.req         = rand_xfer();
      tx_if.req_valid   = (c < 8);
      rx_if.req_valid   = (c < 8);
      tx_if.rsp_ready   = 1'b1;
      rx_if.rsp_ready   = 1'b1;
      idma_if.req_ready = 1'b1;
      idma_if.rsp_valid = (c >= 8);
      #1;
      n_tests++;
      if (obs !== exp_vec() || (m_issuing && idma_if.req !== m_desc)) begin
        n_fail++;
        $display("FAIL rr_both cyc %0d: got %b want %b", c, obs, exp_vec());
      end
      if (tx_if.req_ready === 1'b1 || rx_if.req_ready === 1'b1) begin
        if (ng < 4) gv[ng] = rx_if.req_ready;
        ng++;
      end
      if (tx_if.rsp_valid === 1'b1 || rx_if.rsp_valid === 1'b1) begin
        if (nr < 4) rv[nr] = rx_if.rsp_valid;
        nr++;
      end
      advance();
    end
    n_tests++;
    if (ng != 4 || nr != 4 || gv !== 4'b1010 || rv !== 4'b1010) begin
      n_fail++;
      $display("FAIL rr_order: got grants %0d/%b rsps %0d/%b want 4/1010 4/1010",
               ng, gv, nr, rv);
    end
  endtask

  task automatic test_max_outstanding();
    int acc;
    acc = 0;
    do_reset();
    for (int c = 0; c < 14; c++) begin
      tx_if.req         = rand_xfer();
      tx_if.req_valid   = 1'b1;
      tx_if.rsp_ready   = 1'b1;
      idma_if.req_ready = 1'b1;
      idma_if.rsp_valid = (c == 12);
      #1;
      n_tests++;
      if (obs !== exp_vec() || (m_issuing && idma_if.req !== m_desc)) begin
        n_fail++;
        $display("FAIL max_out cyc %0d: got %b want %b", c, obs, exp_vec());
      end
      if (c < 12 && tx_if.req_ready === 1'b1) acc++;
      if (c >= 12) begin
        n_tests++;
        if (tx_if.req_ready !== (c == 13)) begin
          n_fail++;
          $display("FAIL max_out_regrant cyc %0d: got ready %b want %b",
                   c, tx_if.req_ready, (c == 13));
        end
      end
      advance();
    end
    n_tests++;
    if (acc != 4) begin
      n_fail++;
      $display("FAIL max_out_accepts: got %0d want 4", acc);
    end
  endtask

  task automatic test_stall();
    xfer_t d0;
    do_reset();
    d0 = rand_xfer();
    for (int c = 0; c < 13; c++) begin
      tx_if.req         = (c == 0) ? d0 : rand_xfer();
      rx_if.req         = rand_xfer();
      tx_if.req_valid   = 1'b1;
      rx_if.req_valid   = (c > 0);
      idma_if.req_ready = (c >= 11);
      #1;
      n_tests++;
      if (obs !== exp_vec() || (m_issuing && idma_if.req !== m_desc)) begin
        n_fail++;
        $display("FAIL stall cyc %0d: got %b want %b", c, obs, exp_vec());
      end
      if (c >= 1 && c <= 10) begin
        n_tests++;
        if (idma_if.req !== d0 || tx_if.req_ready !== 1'b0 || rx_if.req_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL stall_hold cyc %0d: got req %h rdy %b%b want %h 00", c,
                   idma_if.req, tx_if.req_ready, rx_if.req_ready, d0);
        end
      end
      advance();
    end
  endtask

  task automatic test_rsp_error();
    do_reset();
    for (int c = 0; c < 7; c++) begin
      rx_if.req         = rand_xfer();
      rx_if.req_valid   = (c == 0);
      idma_if.req_ready = 1'b1;
      idma_if.rsp_valid = (c >= 2 && c <= 5);
      idma_if.rsp_error = (c >= 2 && c <= 5);
      rx_if.rsp_ready   = (c >= 5);
      tx_if.rsp_ready   = 1'b1;
      #1;
      n_tests++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL rsp_err cyc %0d: got %b want %b", c, obs, exp_vec());
      end
      if (c >= 2 && c <= 5) begin
        n_tests++;
        if (idma_if.rsp_ready !== (c == 5) || rx_if.rsp_error !== 1'b1) begin
          n_fail++;
          $display("FAIL rsp_err_hs cyc %0d: got rdy %b err %b want %b 1",
                   c, idma_if.rsp_ready, rx_if.rsp_error, (c == 5));
        end
      end
      advance();
    end
`ifdef ETH_IDMA_ARB_STATS_EN
    n_tests++;
    if (err_cnt !== 32'd1 || rx_done_cnt !== 32'd1 || tx_done_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL rsp_err_stats: got err %0d rx %0d tx %0d want 1 1 0",
               err_cnt, rx_done_cnt, tx_done_cnt);
    end
`endif
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      tx_if.req         = rand_xfer();
      rx_if.req         = rand_xfer();
      tx_if.req_valid   = 1'b1;
      rx_if.req_valid   = 1'b1;
      idma_if.req_ready = (c != 5);
      #1;
      n_tests++;
      if (obs !== exp_vec() || (m_issuing && idma_if.req !== m_desc)) begin
        n_fail++;
        $display("FAIL reset_mid cyc %0d: got %b want %b", c, obs, exp_vec());
      end
      advance();
    end
    clear_inputs();
    rst_ni = 1'b0;
    #1;
    n_tests++;
    if (obs !== 12'd0 || idma_if.req !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_clear: got %b req %h want 0", obs, idma_if.req);
    end
    @(posedge clk);
    #1 rst_ni = 1'b1;
    model_reset();
    tx_if.req_valid = 1'b1;
    rx_if.req_valid = 1'b1;
    #1;
    n_tests++;
    if (obs !== exp_vec() || tx_if.req_ready !== 1'b1 || rx_if.req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_regrant: got %b want %b (tx first)", obs, exp_vec());
    end
    advance();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      tx_if.req         = rand_xfer();
      rx_if.req         = rand_xfer();
      tx_if.req_valid   = ($urandom % 3) != 0;
      rx_if.req_valid   = ($urandom % 2) != 0;
      tx_if.rsp_ready   = ($urandom % 3) != 0;
      rx_if.rsp_ready   = ($urandom % 3) != 0;
      idma_if.req_ready = ($urandom % 3) != 0;
      idma_if.rsp_valid = (m_q.size() != 0) && (($urandom % 4) != 0);
      idma_if.rsp_error = ($urandom % 5) == 0;
      #1;
      n_tests++;
      if (obs !== exp_vec() || (m_issuing && idma_if.req !== m_desc)) begin
        n_fail++;
        $display("FAIL random cyc %0d: got %b req %h want %b req %h",
                 c, obs, idma_if.req, exp_vec(), m_desc);
      end
      advance();
    end
`ifdef ETH_IDMA_ARB_STATS_EN
    n_tests++;
    if (tx_done_cnt !== m_done[0] || rx_done_cnt !== m_done[1] || err_cnt !== m_err) begin
      n_fail++;
      $display("FAIL random_stats: got %0d %0d %0d want %0d %0d %0d",
               tx_done_cnt, rx_done_cnt, err_cnt, m_done[0], m_done[1], m_err);
    end
`endif
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    model_reset();
    test_reset();
    test_tx_single();
    test_rr_both();
    test_max_outstanding();
    test_stall();
    test_rsp_error();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
